// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver (uart_rx) and the existing transmitter.
// Frame width, default bit timing and the receiver state encoding live here so
// both ends of the link agree on framing.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_STOP_BITS    = 1;
    // 27 MHz system clock / 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT = 234;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } uart_rx_state_e;

    // Even parity bit for a data word: 1 when the word has an odd number of ones.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so the
// line looks idle (no false start bit) while coming out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronization of the raw line into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8-bit asynchronous serial receiver with a valid/ready holding register.
// Default framing is 8N1. Define UART_RX_PARITY_EN for 8E1 framing with
// parity checking; otherwise parity_err is tied low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned DW   = UART_DATA_BITS;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DW);

    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DW - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    uart_rx_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] bit_idx_q, bit_idx_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic            done_q, done_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;

    logic [DW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
`endif

    // Receive state machine: next state, counters, shift register and pulses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Glitch shorter than half a bit: not a real start bit.
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DW-1:1]};
                    if (bit_idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ uart_even_parity(shift_q);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Re-arm immediately so a start bit right after stop is caught.
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
`else
                        done_d = 1'b1;
`endif
                    end else begin
                        // Framing error takes precedence over any parity error.
                        frame_err_d = 1'b1;
                        state_d     = StBreakWait;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreakWait: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict held from the parity sample until the stop sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
        end
    end
`endif

    // Holding register: load completed byte, drain on ready, flag overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done_q) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit. Honours UART_RX_PARITY_EN
// (8E1 framing and parity checks) when defined.
module tb_uart_rx;

    localparam int BIT  = 16;
    localparam int HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Sampled start edge to rx_valid: sync + half bit + remaining bit periods + load.
    localparam int LAT = 2 + HALF + (FRAME_BITS - 1) * BIT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: runs 1 time unit after each rising edge.
    int         cyc = 0;
    int         rise_cyc = 0;
    int         valid_rises = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         busy_run = 0;
    int         busy_last = 0;
    logic [7:0] rise_data = 8'h00;
    logic       valid_prev = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (rx_valid && !valid_prev) begin
            valid_rises = valid_rises + 1;
            rise_cyc    = cyc;
            rise_data   = rx_data;
        end
        valid_prev = rx_valid;
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
        if (busy) begin
            busy_run = busy_run + 1;
        end else begin
            if (busy_run != 0) busy_last = busy_run;
            busy_run = 0;
        end
    end

    int t_start = 0;
    int v0, fe0, ov0, pe0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic snap();
        v0  = valid_rises;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
    endtask

    // Frame bits LSB first: start, data, [parity], stop. Line left at the stop level.
    task automatic send_byte(input logic [7:0] d, input logic par, input logic stop_b);
        logic [10:0] frame;
`ifdef UART_RX_PARITY_EN
        frame = {stop_b, par, d, 1'b0};
`else
        frame = {par, stop_b, d, 1'b0};
`endif
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx = frame[i];
            if (i == 0) t_start = cyc;
            tick(BIT);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        rst = 1'b1;
        tick(4);

        // 0x55 with ready high: latency and data
        rx_ready = 1'b1;
        snap();
        send_byte(8'h55, ^8'h55, 1'b1);
        tick(4);
        check("t1_rises", 32'(valid_rises - v0), 32'd1);
        check("t1_latency", 32'(rise_cyc - t_start - 1), 32'(LAT));
        check("t1_data", 32'(rise_data), 32'h55);
        check("t1_drained", 32'(rx_valid), 32'h0);
        check("t1_no_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t1_no_ov", 32'(ov_cnt - ov0), 32'd0);
        check("t1_no_pe", 32'(pe_cnt - pe0), 32'd0);

        // Back-to-back 0xA3, 0x0F with ready low: overrun on the second
        rx_ready = 1'b0;
        snap();
        send_byte(8'hA3, ^8'hA3, 1'b1);
        send_byte(8'h0F, ^8'h0F, 1'b1);
        tick(4);
        check("t2_rises", 32'(valid_rises - v0), 32'd1);
        check("t2_overrun", 32'(ov_cnt - ov0), 32'd1);
        check("t2_held_data", 32'(rx_data), 32'hA3);
        check("t2_held_valid", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("t2_accept_valid", 32'(rx_valid), 32'h0);
        check("t2_accept_data", 32'(rx_data), 32'hA3);

        // 0xFF with low stop bit, line held low 40 more bit times
        rx_ready = 1'b1;
        snap();
        send_byte(8'hFF, ^8'hFF, 1'b0);
        tick(40 * BIT);
        rx = 1'b1;
        tick(2 * BIT);
        check("t3_one_fe", 32'(fe_cnt - fe0), 32'd1);
        check("t3_no_valid", 32'(valid_rises - v0), 32'd0);
        check("t3_idle", 32'(busy), 32'h0);
        send_byte(8'h12, ^8'h12, 1'b1);
        tick(4);
        check("t3_next_rise", 32'(valid_rises - v0), 32'd1);
        check("t3_next_data", 32'(rise_data), 32'h12);
        check("t3_fe_still_one", 32'(fe_cnt - fe0), 32'd1);

        // 4-cycle glitch on idle line
        snap();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * BIT);
        check("t4_no_valid", 32'(valid_rises - v0), 32'd0);
        check("t4_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 32'd0);
        check("t4_busy_len", 32'(busy_last > 0 && busy_last <= HALF), 32'h1);
        check("t4_idle", 32'(busy), 32'h0);

        // Reset mid-DATA of 0x81, then 0x3C
        rx_ready = 1'b1;
        rx = 1'b0;
        tick(BIT);
        rx = 1'b1;
        tick(BIT);
        rx = 1'b0;
        tick(3 * BIT);
        check("t5_busy_before", 32'(busy), 32'h1);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check("t5_rst_data", 32'(rx_data), 32'h00);
        check("t5_rst_valid", 32'(rx_valid), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_pulses", 32'({frame_err, overrun, parity_err}), 32'h0);
        tick(3);
        rst = 1'b1;
        tick(2 * BIT);
        snap();
        send_byte(8'h3C, ^8'h3C, 1'b1);
        tick(4);
        check("t5_rises", 32'(valid_rises - v0), 32'd1);
        check("t5_data", 32'(rise_data), 32'h3C);
        check("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity: wrong bit dropped, correct bit accepted
        snap();
        send_byte(8'h07, 1'b0, 1'b1);
        tick(4);
        check("t6_pe", 32'(pe_cnt - pe0), 32'd1);
        check("t6_no_valid", 32'(valid_rises - v0), 32'd0);
        send_byte(8'h07, 1'b1, 1'b1);
        tick(4);
        check("t6_good_rise", 32'(valid_rises - v0), 32'd1);
        check("t6_good_data", 32'(rise_data), 32'h07);
        check("t6_pe_still_one", 32'(pe_cnt - pe0), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
